mb_pipe_mul: RTL
================

# mb_pipe_mul

Parametrised, pipelined radix-4 modified-Booth multiplier with valid/ready flow control and per-transaction signed/unsigned mode. It takes two WIDTH-bit operands, registers them, generates WIDTH/2+1 Booth partial products, and reduces them through a carry-save compressor tree to a registered 2·WIDTH-bit sum/carry pair. It sits in the same slot as the fixed 8-bit Booth multiplier test wrapper, feeding downstream carry-propagate adders or accumulators. A final carry-propagate stage can be compiled in (see Configuration).

## Interface
- WIDTH, 8, operand width; must be even and ≥ 4
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  asynchronous, active-low reset
- in_valid  in  1  operand pair (mx, my, tc) presented
- in_ready  out  1  block accepts the operand pair this cycle
- mx  in  WIDTH  multiplicand
- my  in  WIDTH  multiplier (Booth-recoded)
- tc  in  1  1 = both operands two's complement, 0 = both unsigned
- mx_reg  out  WIDTH  stage-1 registered multiplicand
- my_reg  out  WIDTH  stage-1 registered multiplier
- out_valid  out  1  sum/carry (and product) hold a result
- out_ready  in  1  downstream consumes result this cycle
- sum  out  2·WIDTH  carry-save sum vector
- carry  out  2·WIDTH  carry-save carry vector, already aligned (no further shift)
- product  out  2·WIDTH  resolved product; present only with MB_FINAL_CPA_EN

## Operation
- Stage S1: registers mx, my, tc and s1_valid on acceptance (in_valid && in_ready).
- Booth recoding from S1 registers: my extended to WIDTH+2 bits (sign-extended if tc=1, zero-extended if tc=0); digits d_i ∈ {−2,−1,0,+1,+2}, i = 0..WIDTH/2, from triplets {y[2i+1], y[2i], y[2i−1]}, y[−1]=0.
- mx extended to WIDTH+1 bits per tc before ×1/×2 selection; negation by inversion plus a hot-one injected in the tree.
- Sign-extension of partial products via the constant-vector (sign-inversion) method; all arithmetic is modulo 2^(2·WIDTH).
- Required invariant: (sum + carry) mod 2^(2·WIDTH) = mx × my, interpreted per tc, for every result.
- Stage S2: registers sum, carry, out_valid.
- Flow control: s2_en = !out_valid || out_ready; s1_en = !s1_valid || s2_en; in_ready = s1_en (combinational, no bubble at full throughput).
- S2 loads when s2_en; out_valid ← s1_valid. S1 loads when s1_en; s1_valid ← in_valid.
- While stalled (out_valid && !out_ready), S2 outputs hold stable; S1 holds its operand; in_ready = 0 if S1 also full.
- Operands on mx/my/tc are ignored when in_valid = 0 or in_ready = 0.

## Timing
- Reset (RST=0, async): s1_valid, out_valid, mx_reg, my_reg, sum, carry, product, internal tc all 0; in_ready = 1 once RST released.
- Latency: accepted at edge N → out_valid with result after edge N+1 (2 cycles input to output register).
- Throughput: one result per cycle when out_ready held 1.
- Simultaneous accept and consume on a full pipeline: permitted, no data loss or duplication.
- Reset mid-operation: all in-flight results discarded; no out_valid after release until new acceptance.

## Configuration
- MB_FINAL_CPA_EN defined: adds stage S3 computing product = sum + carry (2·WIDTH bits, carry-out discarded); out_valid, flow control, and stall rules move to S3; latency 3 cycles; sum/carry outputs are S3-registered copies aligned with product.
- Undefined: no product port, latency 2, downstream resolves sum + carry.

## Test plan
- WIDTH=8, tc=1, mx=0x80, my=0x80, out_ready=1 → after 2 cycles out_valid=1, (sum+carry) mod 2^16 = 0x4000.
- WIDTH=8, tc=0, mx=0xFF, my=0xFF → result 0xFE01; same operands with tc=1 → 0x0001.
- WIDTH=8, tc=1, mx=0xFF, my=0x01 → 0xFFFF; mx=0x7F, my=0x80 → 0xC080.
- Back-pressure: stream 4 operand pairs with out_ready=0 for 3 cycles → in_ready drops after 2 accepted, outputs hold, all 4 results emerge in order with no loss or duplication.
- Reset asserted with 2 results in flight → out_valid=0, sum=carry=0 immediately; after release nothing emitted until new input.
- WIDTH=16, random 10k pairs both tc modes, random out_ready → every result matches reference product; repeat with MB_FINAL_CPA_EN, latency 3, product = sum+carry.

Source files
------------

// File: rtl/mb_pipe_mul.sv
// Pipelined radix-4 modified-Booth multiplier with a registered carry-save (sum, carry) result.
// Define MB_FINAL_CPA_EN to add a third stage that also registers product = sum + carry.
module mb_pipe_mul #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   mx,
    input  logic [WIDTH-1:0]   my,
    input  logic               tc,
    output logic [WIDTH-1:0]   mx_reg,
    output logic [WIDTH-1:0]   my_reg,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] sum,
    output logic [2*WIDTH-1:0] carry
`ifdef MB_FINAL_CPA_EN
    ,
    output logic [2*WIDTH-1:0] product
`endif
);

    localparam int unsigned PW   = 2 * WIDTH;
    localparam int unsigned NPP  = WIDTH / 2 + 1;
    localparam int unsigned XW   = WIDTH + 2;
    localparam int unsigned NROW = NPP + 2;

    // Sum of -2^(XW-1) * 4^i over all rows: compensates the inverted partial-product sign bits.
    function automatic logic [PW-1:0] sign_const();
        logic [PW-1:0] k;
        k = '0;
        for (int i = 0; i < NPP; i++) begin
            k = k - ({{(PW-1){1'b0}}, 1'b1} << (XW - 1 + 2 * i));
        end
        return k;
    endfunction

    localparam logic [PW-1:0] SignConst = sign_const();

    logic             s1_en, s2_en;
    logic             s1_valid_q, tc_q;
    logic [WIDTH-1:0] mx_q, my_q;
    logic             s2_valid_q;
    logic [PW-1:0]    sum2_q, carry2_q;

    // Stage S1: operand registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s1_valid_q <= 1'b0;
            tc_q       <= 1'b0;
            mx_q       <= '0;
            my_q       <= '0;
        end else if (s1_en) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                tc_q <= tc;
                mx_q <= mx;
                my_q <= my;
            end
        end
    end

    logic [WIDTH+2:0] y_ext;
    logic [XW-1:0]    x1, x2, pp;
    logic [2:0]       trip;
    logic             neg;
    logic [PW-1:0]    row_tmp, neg_row, cs_s, cs_c, cs_t;
    logic [PW-1:0]    rows [NROW];

    always_comb begin
        // Bit 0 is the implicit y[-1] = 0, so triplet i sits at y_ext[2i+2:2i].
        y_ext   = {{2{tc_q & my_q[WIDTH-1]}}, my_q, 1'b0};
        x1      = {{2{tc_q & mx_q[WIDTH-1]}}, mx_q};
        x2      = {x1[XW-2:0], 1'b0};
        trip    = '0;
        pp      = '0;
        neg     = 1'b0;
        row_tmp = '0;
        neg_row = '0;
        for (int i = 0; i < NPP; i++) begin
            trip = y_ext[2*i +: 3];
            case (trip)
                3'b001, 3'b010: pp = x1;
                3'b011:         pp = x2;
                3'b100:         pp = ~x2;
                3'b101, 3'b110: pp = ~x1;
                default:        pp = '0;
            endcase
            neg          = trip[2] & ~(trip[1] & trip[0]);
            row_tmp      = '0;
            row_tmp[XW-1:0] = {~pp[XW-1], pp[XW-2:0]};
            rows[i]      = row_tmp << (2 * i);
            neg_row[2*i] = neg;
        end
        rows[NPP]   = neg_row;
        rows[NPP+1] = SignConst;

        // 3:2 carry-save reduction of all rows down to one sum/carry pair.
        cs_s = rows[0];
        cs_c = rows[1];
        cs_t = '0;
        for (int j = 2; j < NROW; j++) begin
            cs_t = cs_s ^ cs_c ^ rows[j];
            cs_c = ((cs_s & cs_c) | (cs_s & rows[j]) | (cs_c & rows[j])) << 1;
            cs_s = cs_t;
        end
    end

    // Stage S2: carry-save result registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s2_valid_q <= 1'b0;
            sum2_q     <= '0;
            carry2_q   <= '0;
        end else if (s2_en) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                sum2_q   <= cs_s;
                carry2_q <= cs_c;
            end
        end
    end

`ifdef MB_FINAL_CPA_EN
    logic          s3_en, s3_valid_q;
    logic [PW-1:0] sum3_q, carry3_q, prod_q;

    // Stage S3: resolved product plus aligned copies of the carry-save pair.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s3_valid_q <= 1'b0;
            sum3_q     <= '0;
            carry3_q   <= '0;
            prod_q     <= '0;
        end else if (s3_en) begin
            s3_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                sum3_q   <= sum2_q;
                carry3_q <= carry2_q;
                prod_q   <= sum2_q + carry2_q;
            end
        end
    end

    assign s3_en     = !s3_valid_q || out_ready;
    assign s2_en     = !s2_valid_q || s3_en;
    assign out_valid = s3_valid_q;
    assign sum       = sum3_q;
    assign carry     = carry3_q;
    assign product   = prod_q;
`else
    assign s2_en     = !s2_valid_q || out_ready;
    assign out_valid = s2_valid_q;
    assign sum       = sum2_q;
    assign carry     = carry2_q;
`endif

    assign s1_en    = !s1_valid_q || s2_en;
    assign in_ready = s1_en;
    assign mx_reg   = mx_q;
    assign my_reg   = my_q;

endmodule
